// File: rtl/keynsham_arb_ram.sv
// -----------------------------------------------------------------------------
// keynsham_arb_ram
//
// On-chip RAM shared by the instruction and data buses of the Keynsham SoC.
// One single-port array (split into four byte lanes so byte enables map onto
// block-RAM write enables) sits behind a round-robin arbiter. Each access is
// issued to the array in its grant cycle, optionally stretched by a fixed
// number of wait states, and completed with a one-cycle registered ack.
// Read data is forced to zero whenever the matching ack is low so several
// slaves' outputs can simply be OR-combined.
//
// Parameters
//   bus_address  byte base address of the address window
//   bus_size     window size in bytes (multiple of 4)
//   addr_bits    word-address width of the array (depth = 2**addr_bits)
//   wait_states  extra cycles (0..7) between grant and ack
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   i_access/i_addr           instruction request (full-word reads only)
//   i_cs                      combinational: i_addr inside window
//   i_data/i_ack              instruction read data and completion pulse
//   d_access/d_addr           data request
//   d_bytesel/d_wr_val/d_wr_en byte enables, write data, write select
//   d_cs                      combinational: d_addr inside window
//   d_data/d_ack              data read data and completion pulse
// -----------------------------------------------------------------------------
module keynsham_arb_ram #(
    parameter logic [31:0] bus_address = 32'h0,
    parameter logic [31:0] bus_size    = 32'h0,
    parameter int          addr_bits   = 10,
    parameter int          wait_states = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_access,
    output logic        i_cs,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    input  logic        d_access,
    output logic        d_cs,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    input  logic        d_wr_en,
    output logic [31:0] d_data,
    output logic        d_ack
);

    localparam int          DEPTH     = 1 << addr_bits;
    localparam logic [32:0] WIN_LO    = {1'b0, bus_address} >> 2;
    localparam logic [32:0] WIN_HI    = ({1'b0, bus_address} + {1'b0, bus_size}) >> 2;
    localparam bit          HAS_WAIT  = (wait_states > 0);
    localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(wait_states - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    // Window test done with borrow bits of 34-bit subtractions so that a zero
    // base address does not turn into a constant comparison.
    function automatic logic in_window(input logic [29:0] a);
        logic [33:0] lo_diff;
        logic [33:0] hi_diff;
        lo_diff   = {4'b0, a} - {1'b0, WIN_LO};
        hi_diff   = {4'b0, a} - {1'b0, WIN_HI};
        in_window = ~lo_diff[33] & hi_diff[33];
    endfunction

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 gnt_q, gnt_d;      // bus granted most recently: 1 = data
    logic                 wr_q, wr_d;        // access in flight is a write
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;

    logic                 can_grant;
    logic                 i_elig;
    logic                 d_elig;
    logic                 grant_valid;
    logic                 grant_data;
    logic                 mem_en;
    logic                 mem_we;
    logic [addr_bits-1:0] mem_idx;
    logic [31:0]          rd_word;

    assign i_cs = in_window(i_addr);
    assign d_cs = in_window(d_addr);

    // A bus whose ack is high this cycle sits out this arbitration round, which
    // is what lets the other bus slot in back-to-back.
    assign can_grant   = (state_q == ST_IDLE) || (state_q == ST_ACK);
    assign i_elig      = i_access & i_cs & ~i_ack_q;
    assign d_elig      = d_access & d_cs & ~d_ack_q;
    assign grant_valid = can_grant & (i_elig | d_elig);
    // On a tie the bus that did not win last time takes it.
    assign grant_data  = d_elig & (~i_elig | ~gnt_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ACK: begin
                if (grant_valid) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_ACK;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: array controls for the grant cycle and the next ack pulse
    always_comb begin
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        mem_en  = grant_valid;
        mem_we  = grant_valid & grant_data & d_wr_en;
        mem_idx = grant_data ? d_addr[addr_bits-1:0] : i_addr[addr_bits-1:0];
        if (grant_valid) begin
            gnt_d = grant_data;
            wr_d  = grant_data & d_wr_en;
        end
        i_ack_d = (state_d == ST_ACK) & ~gnt_d;
        d_ack_d = (state_d == ST_ACK) & gnt_d;
    end

    // Byte-lane array with registered read. The read register holds its value
    // until the next grant, so it stays valid through any wait states and the
    // ack cycle; outputs are gated by the acks, which reset asynchronously.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;
            always_ff @(posedge clk) begin
                if (mem_en) begin
                    if (mem_we && d_bytesel[gi]) begin
                        mem[mem_idx] <= d_wr_val[8*gi +: 8];
                    end
                    rd_q <= mem[mem_idx];
                end
            end
            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign i_ack  = i_ack_q;
    assign d_ack  = d_ack_q;
    assign i_data = i_ack_q ? rd_word : 32'h0;
    assign d_data = (d_ack_q && !wr_q) ? rd_word : 32'h0;

endmodule

// File: tb/tb_keynsham_arb_ram.sv
module tb_keynsham_arb_ram;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_access [N];
    logic        i_cs     [N];
    logic [29:0] i_addr   [N];
    logic [31:0] i_data   [N];
    logic        i_ack    [N];
    logic        d_access [N];
    logic        d_cs     [N];
    logic [29:0] d_addr   [N];
    logic [3:0]  d_bytesel[N];
    logic [31:0] d_wr_val [N];
    logic        d_wr_en  [N];
    logic [31:0] d_data   [N];
    logic        d_ack    [N];

    // Instances: 0 ws=0, 1 ws=2, 2 ws=3, 3 ws=7 (window 0x1000/0x1000, 1024 words);
    // 4 ws=0 with a 16-word array behind a 64 KiB window.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            keynsham_arb_ram #(
                .bus_address(gi == 4 ? 32'h0 : 32'h1000),
                .bus_size   (gi == 4 ? 32'h10000 : 32'h1000),
                .addr_bits  (gi == 4 ? 4 : 10),
                .wait_states(gi == 1 ? 2 : gi == 2 ? 3 : gi == 3 ? 7 : 0)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_access (i_access[gi]),
                .i_cs     (i_cs[gi]),
                .i_addr   (i_addr[gi]),
                .i_data   (i_data[gi]),
                .i_ack    (i_ack[gi]),
                .d_access (d_access[gi]),
                .d_cs     (d_cs[gi]),
                .d_addr   (d_addr[gi]),
                .d_bytesel(d_bytesel[gi]),
                .d_wr_val (d_wr_val[gi]),
                .d_wr_en  (d_wr_en[gi]),
                .d_data   (d_data[gi]),
                .d_ack    (d_ack[gi])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;

    // Reference model: word memory per instance, indexed by address mod depth
    logic [31:0] mdl [N][1024];
    bit          mv  [N][1024];

    function automatic int ws_of(input int k);
        return (k == 1) ? 2 : (k == 2) ? 3 : (k == 3) ? 7 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 4) ? 16 : 1024;
    endfunction

    task automatic mdl_write(input int k, input logic [29:0] a, input logic [3:0] be,
                             input logic [31:0] v);
        int idx;
        idx = int'(a) % depth_of(k);
        for (int b = 0; b < 4; b++)
            if (be[b]) mdl[k][idx][8*b +: 8] = v[8*b +: 8];
        if (be == 4'hF) mv[k][idx] = 1'b1;
    endtask

    function automatic logic [31:0] mdl_read(input int k, input logic [29:0] a);
        return mdl[k][int'(a) % depth_of(k)];
    endfunction

    // Data-bus transfer. lat = edges from request to ack (-1 on timeout),
    // ack2 = d_ack one cycle after the ack, stray = idle-cycle output violations.
    task automatic d_xfer(input int k, input logic we, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] v, input int budget,
                          output int lat, output logic [31:0] data, output logic ack2,
                          output int stray);
        @(posedge clk); #1;
        d_addr[k] = a; d_wr_en[k] = we; d_bytesel[k] = be; d_wr_val[k] = v;
        d_access[k] = 1'b1;
        lat = -1; data = 32'h0; stray = 0; ack2 = 1'b0;
        for (int n = 1; n <= budget + 1 && lat < 0; n++) begin
            @(negedge clk);
            if (i_ack[k] || i_data[k] != 32'h0) stray++;
            if (d_ack[k]) begin
                lat  = n - 1;
                data = d_data[k];
            end else if (d_data[k] != 32'h0) begin
                stray++;
            end
        end
        @(posedge clk); #1;
        d_access[k] = 1'b0;
        @(negedge clk);
        ack2 = d_ack[k];
    endtask

    task automatic i_xfer(input int k, input logic [29:0] a, input int budget,
                          output int lat, output logic [31:0] data, output logic ack2,
                          output int stray);
        @(posedge clk); #1;
        i_addr[k] = a;
        i_access[k] = 1'b1;
        lat = -1; data = 32'h0; stray = 0; ack2 = 1'b0;
        for (int n = 1; n <= budget + 1 && lat < 0; n++) begin
            @(negedge clk);
            if (d_ack[k] || d_data[k] != 32'h0) stray++;
            if (i_ack[k]) begin
                lat  = n - 1;
                data = i_data[k];
            end else if (i_data[k] != 32'h0) begin
                stray++;
            end
        end
        @(posedge clk); #1;
        i_access[k] = 1'b0;
        @(negedge clk);
        ack2 = i_ack[k];
    endtask

    task automatic test_reset();
        logic [31:0] v, got;
        logic        a2;
        int          lat, stray, hits;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (i_ack[k] !== 1'b0 || d_ack[k] !== 1'b0 || i_data[k] !== 32'h0 || d_data[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d: got acks %b%b data %h %h required all 0",
                         k, i_ack[k], d_ack[k], i_data[k], d_data[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;

        v = $urandom;
        d_xfer(2, 1'b1, 30'h410, 4'hF, v, 20, lat, got, a2, stray);
        mdl_write(2, 30'h410, 4'hF, v);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL reset_prewrite_lat: got %0d required 4", lat);
        end

        // Start a read, then reset while it sits in its wait states
        @(posedge clk); #1;
        d_addr[2] = 30'h410; d_wr_en[2] = 1'b0; d_bytesel[2] = 4'hF; d_access[2] = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_ack[2] !== 1'b0 || d_data[2] !== 32'h0 || i_ack[2] !== 1'b0 || i_data[2] !== 32'h0) begin
            errors++;
            $display("FAIL reset_midwait: got acks %b%b data %h %h required all 0",
                     i_ack[2], d_ack[2], i_data[2], d_data[2]);
        end
        d_access[2] = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack[2]) hits++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (d_ack[2]) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d acks required 0", hits);
        end

        d_xfer(2, 1'b0, 30'h410, 4'hF, 32'h0, 20, lat, got, a2, stray);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL reset_after_lat: got %0d required 4", lat);
        end
        checks++;
        if (got !== mdl_read(2, 30'h410)) begin
            errors++;
            $display("FAIL reset_after_data: got %h required %h", got, mdl_read(2, 30'h410));
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] got;
        logic        a2;
        int          lat, stray;
        d_xfer(0, 1'b1, 30'h400, 4'hF, 32'h11223344, 20, lat, got, a2, stray);
        mdl_write(0, 30'h400, 4'hF, 32'h11223344);
        d_xfer(0, 1'b1, 30'h400, 4'b0010, 32'hAABBCCDD, 20, lat, got, a2, stray);
        mdl_write(0, 30'h400, 4'b0010, 32'hAABBCCDD);
        checks++;
        if (lat !== 1 || got !== 32'h0) begin
            errors++;
            $display("FAIL byte_write_ack: got lat %0d data %h required lat 1 data 0", lat, got);
        end
        checks++;
        if (stray != 0 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL byte_write_idle: got stray %0d ack2 %b required 0 0", stray, a2);
        end
        d_xfer(0, 1'b0, 30'h400, 4'hF, 32'h0, 20, lat, got, a2, stray);
        checks++;
        if (got !== mdl_read(0, 30'h400) || stray != 0) begin
            errors++;
            $display("FAIL byte_readback: got %h stray %0d required %h stray 0",
                     got, stray, mdl_read(0, 30'h400));
        end
    endtask

    task automatic test_latency();
        logic [31:0] got, v;
        logic        a2;
        int          lat, stray, k;
        for (int s = 0; s < 3; s++) begin
            k = (s == 0) ? 0 : (s == 1) ? 1 : 3;
            v = $urandom;
            d_xfer(k, 1'b1, 30'h600, 4'hF, v, 20, lat, got, a2, stray);
            mdl_write(k, 30'h600, 4'hF, v);
            i_xfer(k, 30'h600, 20, lat, got, a2, stray);
            checks++;
            if (lat !== 1 + ws_of(k) || a2 !== 1'b0) begin
                errors++;
                $display("FAIL latency_i inst %0d: got lat %0d ack2 %b required lat %0d ack2 0",
                         k, lat, a2, 1 + ws_of(k));
            end
            checks++;
            if (got !== mdl_read(k, 30'h600) || stray != 0) begin
                errors++;
                $display("FAIL latency_data inst %0d: got %h stray %0d required %h stray 0",
                         k, got, stray, mdl_read(k, 30'h600));
            end
        end
    endtask

    task automatic test_window();
        logic [31:0] got;
        logic        a2;
        int          lat, stray;
        logic [29:0] probe [4];
        logic        exp_cs [4];
        probe[0] = 30'h3FF; exp_cs[0] = 1'b0;
        probe[1] = 30'h400; exp_cs[1] = 1'b1;
        probe[2] = 30'h7FF; exp_cs[2] = 1'b1;
        probe[3] = 30'h800; exp_cs[3] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            i_addr[0] = probe[p];
            d_addr[0] = probe[p];
            #1;
            checks++;
            if (i_cs[0] !== exp_cs[p] || d_cs[0] !== exp_cs[p]) begin
                errors++;
                $display("FAIL cs_decode addr %h: got i_cs %b d_cs %b required %b",
                         probe[p], i_cs[0], d_cs[0], exp_cs[p]);
            end
        end
        // 0x800 aliases onto the index of 0x400, so a stray write would show there
        d_xfer(0, 1'b1, 30'h800, 4'hF, ~mdl_read(0, 30'h400), 20, lat, got, a2, stray);
        checks++;
        if (lat != -1 || stray != 0) begin
            errors++;
            $display("FAIL out_of_window: got lat %0d stray %0d required no ack", lat, stray);
        end
        d_xfer(0, 1'b0, 30'h400, 4'hF, 32'h0, 20, lat, got, a2, stray);
        checks++;
        if (got !== mdl_read(0, 30'h400)) begin
            errors++;
            $display("FAIL out_of_window_unchanged: got %h required %h", got, mdl_read(0, 30'h400));
        end
        d_xfer(0, 1'b1, 30'h7FF, 4'hF, 32'h5A5AC3C3, 20, lat, got, a2, stray);
        mdl_write(0, 30'h7FF, 4'hF, 32'h5A5AC3C3);
        d_xfer(0, 1'b0, 30'h7FF, 4'hF, 32'h0, 20, lat, got, a2, stray);
        checks++;
        if (lat !== 1 || got !== mdl_read(0, 30'h7FF)) begin
            errors++;
            $display("FAIL last_word: got lat %0d data %h required lat 1 data %h",
                     lat, got, mdl_read(0, 30'h7FF));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got, v;
        logic        a2;
        int          lat, stray;
        v = $urandom;
        d_xfer(4, 1'b1, 30'h10, 4'hF, v, 20, lat, got, a2, stray);
        mdl_write(4, 30'h10, 4'hF, v);
        i_xfer(4, 30'h0, 20, lat, got, a2, stray);
        checks++;
        if (lat !== 1 || got !== mdl_read(4, 30'h0)) begin
            errors++;
            $display("FAIL wrap_i: got lat %0d data %h required lat 1 data %h",
                     lat, got, mdl_read(4, 30'h0));
        end
        d_xfer(4, 1'b0, 30'h20, 4'hF, 32'h0, 20, lat, got, a2, stray);
        checks++;
        if (got !== mdl_read(4, 30'h20)) begin
            errors++;
            $display("FAIL wrap_d: got %h required %h", got, mdl_read(4, 30'h20));
        end
    endtask

    task automatic test_random(input int k);
        logic [29:0] q [$];
        logic [29:0] a;
        logic [31:0] got, v;
        logic [3:0]  be;
        logic        a2;
        int          lat, stray, idx;
        for (int n = 0; n < 24; n++) begin
            if (q.size() == 0 || $urandom_range(0, 2) == 0) begin
                a   = 30'h400 + 30'($urandom_range(0, 15));
                idx = int'(a) % depth_of(k);
                be  = mv[k][idx] ? 4'($urandom) : 4'hF;
                v   = $urandom;
                if (!mv[k][idx]) q.push_back(a);
                d_xfer(k, 1'b1, a, be, v, 30, lat, got, a2, stray);
                mdl_write(k, a, be, v);
                checks++;
                if (lat !== 1 + ws_of(k) || a2 !== 1'b0 || got !== 32'h0 || stray != 0) begin
                    errors++;
                    $display("FAIL rand_write inst %0d addr %h: got lat %0d ack2 %b data %h stray %0d required lat %0d ack2 0 data 0 stray 0",
                             k, a, lat, a2, got, stray, 1 + ws_of(k));
                end
            end else begin
                a = q[$urandom_range(0, q.size() - 1)];
                if ($urandom_range(0, 1) == 1)
                    d_xfer(k, 1'b0, a, 4'hF, 32'h0, 30, lat, got, a2, stray);
                else
                    i_xfer(k, a, 30, lat, got, a2, stray);
                checks++;
                if (lat !== 1 + ws_of(k) || a2 !== 1'b0 || got !== mdl_read(k, a) || stray != 0) begin
                    errors++;
                    $display("FAIL rand_read inst %0d addr %h: got lat %0d ack2 %b data %h stray %0d required lat %0d ack2 0 data %h stray 0",
                             k, a, lat, a2, got, stray, 1 + ws_of(k), mdl_read(k, a));
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [31:0] got, exp_data, obs_data;
        logic        a2, exp_d;
        int          lat, stray;
        d_xfer(0, 1'b1, 30'h500, 4'hF, $urandom, 20, lat, got, a2, stray);
        mdl_write(0, 30'h500, 4'hF, d_wr_val[0]);
        d_xfer(0, 1'b1, 30'h501, 4'hF, $urandom, 20, lat, got, a2, stray);
        mdl_write(0, 30'h501, 4'hF, d_wr_val[0]);
        // Both buses requesting straight out of reset
        @(negedge clk);
        rst_n = 1'b0;
        i_addr[0] = 30'h500; i_access[0] = 1'b1;
        d_addr[0] = 30'h501; d_wr_en[0] = 1'b0; d_bytesel[0] = 4'hF; d_access[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            exp_d    = (n % 2 == 0);
            exp_data = exp_d ? mdl_read(0, 30'h501) : mdl_read(0, 30'h500);
            obs_data = exp_d ? d_data[0] : i_data[0];
            checks++;
            if (d_ack[0] !== exp_d || i_ack[0] !== !exp_d || obs_data !== exp_data) begin
                errors++;
                $display("FAIL contention cycle %0d: got i_ack %b d_ack %b data %h required i_ack %b d_ack %b data %h",
                         n, i_ack[0], d_ack[0], obs_data, !exp_d, exp_d, exp_data);
            end
        end
        @(posedge clk); #1;
        i_access[0] = 1'b0;
        d_access[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            i_access[k] = 1'b0; i_addr[k] = 30'h0;
            d_access[k] = 1'b0; d_addr[k] = 30'h0; d_bytesel[k] = 4'h0;
            d_wr_val[k] = 32'h0; d_wr_en[k] = 1'b0;
            for (int w = 0; w < 1024; w++) begin
                mdl[k][w] = 32'h0;
                mv[k][w]  = 1'b0;
            end
        end
        test_reset();
        test_byte_write();
        test_latency();
        test_window();
        test_wrap();
        test_random(0);
        test_random(1);
        test_contention();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
